// File: rtl/pipelined_cpu_pkg.sv
// rtl/pipelined_cpu_pkg.sv - opcodes, function codes, ALU ops and stage records for pipelined_cpu
package pipelined_cpu_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    alu_op_e     op;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write, mem_write, mem_to_reg;
    logic [31:0] alu, sd;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write, mem_to_reg;
    logic [31:0] alu, md;
    logic [4:0]  rd;
  } mem_wb_t;

  function automatic alu_op_e alu_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    alu_op_e op;
    op = ALU_ADD;
    if (opc == OP_R) begin
      if (f7 == F7_MUL) op = ALU_MUL;
      else case (f3)
        F3_ADD:  op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        F3_SLL:  op = ALU_SLL;
        F3_XOR:  op = ALU_XOR;
        F3_AND:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end else if (opc == OP_I && f3 == F3_SRA) begin
      op = ALU_SRA;
    end
    return op;
  endfunction

  // 1 = take EX/MEM result (younger, wins), 2 = take write-back data, 0 = register value
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic exm_rw, input logic [4:0] exm_rd,
                                         input logic mwb_rw, input logic [4:0] mwb_rd);
    if (exm_rw && exm_rd != 5'd0 && exm_rd == rs) return 2'd1;
    if (mwb_rw && mwb_rd != 5'd0 && mwb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction
endpackage

// File: rtl/pipelined_cpu_alu.sv
// rtl/pipelined_cpu_alu.sv - 32-bit wrap-around ALU shared by the EX stage
module pipeline_alu
  import pipelined_cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = a_i + b_i;
    case (alu_op_e'(op_i))
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRA: y_o = $signed(a_i) >>> b_i[4:0];
      ALU_MUL: y_o = a_i * b_i;
      default: y_o = a_i + b_i;
    endcase
  end
endmodule

// File: rtl/pipelined_cpu.sv
// rtl/pipelined_cpu.sv - five-stage RV32 subset pipeline with internal memories and register file
module pc_reg (
  input  logic        clk_i, rst_i, en_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pc_o <= '0;
    else if (en_i) pc_o <= pc_i;
endmodule

module instr_memory #(parameter int WORDS = 256) (
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:WORDS-1];
  assign instr_o = memory[addr_i];
endmodule

module reg_file #(parameter int REGS = 32) (
  input  logic        clk_i, we_i,
  input  logic [4:0]  rs1_i, rs2_i, rd_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o, rd2_o
);
  logic [31:0] register [0:REGS-1];
  always_ff @(posedge clk_i)
    if (we_i && rd_i != 5'd0) register[rd_i] <= wd_i;
  // same-cycle write is visible to the reader so WB needs no extra forwarding path into ID
  assign rd1_o = (rs1_i == 5'd0) ? '0 : (we_i && rs1_i == rd_i) ? wd_i : register[rs1_i];
  assign rd2_o = (rs2_i == 5'd0) ? '0 : (we_i && rs2_i == rd_i) ? wd_i : register[rs2_i];
endmodule

module data_memory #(parameter int WORDS = 32) (
  input  logic        clk_i, we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] memory [0:WORDS-1];
  always_ff @(posedge clk_i)
    if (we_i) memory[addr_i] <= wdata_i;
  assign rdata_o = memory[addr_i];
endmodule

module control_unit
  import pipelined_cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, Branch_o
);
  always_comb begin
    {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, Branch_o} = '0;
    case (opcode_i)
      OP_R:      reg_write_o = 1'b1;
      OP_I:      {reg_write_o, alu_src_o} = 2'b11;
      OP_LOAD:   {reg_write_o, mem_read_o, mem_to_reg_o, alu_src_o} = 4'b1111;
      OP_STORE:  {mem_write_o, alu_src_o} = 2'b11;
      OP_BRANCH: Branch_o = 1'b1;
      default:   ;
    endcase
  end
endmodule

module hazard_unit (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i, rs1_i, rs2_i,
  output logic       STALL
);
  assign STALL = ex_mem_read_i && ex_rd_i != 5'd0 && (ex_rd_i == rs1_i || ex_rd_i == rs2_i);
endmodule

module branch_unit (
  input  logic        branch_i, stall_i,
  input  logic [31:0] a_i, b_i, pc_i, imm_i,
  output logic        FLUSH,
  output logic [31:0] target_o
);
  assign FLUSH    = branch_i && !stall_i && (a_i == b_i);
  assign target_o = pc_i + (imm_i << 1);
endmodule

module pipelined_cpu
  import pipelined_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 32,
  parameter int NUM_REGS   = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  if_id_t  if_id;
  id_ex_t  id_ex, id_d;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic [31:0] pc, instr, target, rd1, rd2, imm, wb_data, fa, fb, alu_y, mem_rdata;
  logic [1:0]  sel_a, sel_b;
  logic        stall, flush, c_rw, c_mr, c_mw, c_m2r, c_as, c_br;
  logic [31:0] ins;
  assign ins = if_id.instr;

  // a taken branch redirects even while start_i is low so the fall-through path is never fetched
  pc_reg PC (.clk_i, .rst_i, .en_i(flush || (start_i && !stall)),
             .pc_i(flush ? target : pc + 32'd4), .pc_o(pc));
  instr_memory #(.WORDS(IMEM_WORDS)) Instruction_Memory (.addr_i(pc[9:2]), .instr_o(instr));

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) if_id <= '0;
    else if (!stall) begin
      if_id.pc    <= pc;
      if_id.instr <= (start_i && !flush) ? instr : 32'd0;
    end

  control_unit Control (.opcode_i(ins[6:0]), .reg_write_o(c_rw), .mem_read_o(c_mr), .mem_write_o(c_mw),
                        .mem_to_reg_o(c_m2r), .alu_src_o(c_as), .Branch_o(c_br));
  reg_file #(.REGS(NUM_REGS)) Registers (.clk_i, .we_i(mem_wb.reg_write), .rs1_i(ins[19:15]), .rs2_i(ins[24:20]),
                                         .rd_i(mem_wb.rd), .wd_i(wb_data), .rd1_o(rd1), .rd2_o(rd2));
  hazard_unit Hazard_Detection_Unit (.ex_mem_read_i(id_ex.mem_read), .ex_rd_i(id_ex.rd),
                                     .rs1_i(ins[19:15]), .rs2_i(ins[24:20]), .STALL(stall));
  branch_unit Branch_Unit (.branch_i(c_br), .stall_i(stall), .a_i(rd1), .b_i(rd2), .pc_i(if_id.pc),
                           .imm_i(imm), .FLUSH(flush), .target_o(target));

  always_comb begin
    imm = {{20{ins[31]}}, ins[31:20]};
    if (ins[6:0] == OP_STORE)       imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else if (ins[6:0] == OP_BRANCH) imm = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
  end

  always_comb begin
    id_d = '{reg_write: c_rw, mem_read: c_mr, mem_write: c_mw, mem_to_reg: c_m2r, alu_src: c_as,
             op: alu_decode(ins[6:0], ins[14:12], ins[31:25]), rd1: rd1, rd2: rd2, imm: imm,
             rs1: ins[19:15], rs2: ins[24:20], rd: ins[11:7]};
    if (stall) {id_d.reg_write, id_d.mem_read, id_d.mem_write, id_d.mem_to_reg, id_d.alu_src} = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) id_ex <= '0;
    else id_ex <= id_d;

  assign sel_a = fwd_sel(id_ex.rs1, ex_mem.reg_write, ex_mem.rd, mem_wb.reg_write, mem_wb.rd);
  assign sel_b = fwd_sel(id_ex.rs2, ex_mem.reg_write, ex_mem.rd, mem_wb.reg_write, mem_wb.rd);
  assign fa = (sel_a == 2'd1) ? ex_mem.alu : (sel_a == 2'd2) ? wb_data : id_ex.rd1;
  assign fb = (sel_b == 2'd1) ? ex_mem.alu : (sel_b == 2'd2) ? wb_data : id_ex.rd2;

  pipeline_alu ALU (.a_i(fa), .b_i(id_ex.alu_src ? id_ex.imm : fb), .op_i(id_ex.op), .y_o(alu_y));

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ex_mem <= '0;
    else ex_mem <= '{reg_write: id_ex.reg_write, mem_write: id_ex.mem_write, mem_to_reg: id_ex.mem_to_reg,
                     alu: alu_y, sd: fb, rd: id_ex.rd};

  data_memory #(.WORDS(DMEM_WORDS)) Data_Memory (.clk_i, .we_i(ex_mem.mem_write), .addr_i(ex_mem.alu[6:2]),
                                                 .wdata_i(ex_mem.sd), .rdata_o(mem_rdata));

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) mem_wb <= '0;
    else mem_wb <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg,
                     alu: ex_mem.alu, md: mem_rdata, rd: ex_mem.rd};

  assign wb_data = mem_wb.mem_to_reg ? mem_wb.md : mem_wb.alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// tb/tb_pipelined_cpu.sv - directed program bench for pipelined_cpu
module tb_pipelined_cpu;
  logic clk_i = 1'b0;
  logic rst_i, start_i;
  int total = 0, bad = 0;
  int n_stall = 0, n_flush = 0, n_branch = 0;
  logic        flush_q = 1'b0;
  logic [31:0] pc_at_flush = '0, pc_after_flush = '0;
  logic [31:0] pc, prog [0:17];

  pipelined_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;
  assign pc = dut.PC.pc_o;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, R};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && pc !== target; i++) @(negedge clk_i);
    chk(tag, pc, target);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      n_stall <= 0; n_flush <= 0; n_branch <= 0; flush_q <= 1'b0;
    end else begin
      if (flush_q) pc_after_flush <= pc;
      flush_q <= dut.Branch_Unit.FLUSH;
      if (dut.Branch_Unit.FLUSH) begin
        n_flush <= n_flush + 1;
        pc_at_flush <= pc;
      end
      if (dut.Hazard_Detection_Unit.STALL) n_stall <= n_stall + 1;
      if (dut.Control.Branch_o) n_branch <= n_branch + 1;
    end
  end

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    prog[0]  = i_t(12'd10, 5'd0, 3'b000, 5'd1, I);
    prog[1]  = i_t(12'd3, 5'd0, 3'b000, 5'd2, I);
    prog[2]  = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    prog[3]  = r_t(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
    prog[4]  = i_t(12'd0, 5'd0, 3'b010, 5'd5, LD);
    prog[5]  = r_t(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
    prog[6]  = s_t(12'd4, 5'd6, 5'd0);
    prog[7]  = i_t(12'hff8, 5'd0, 3'b000, 5'd8, I);
    prog[8]  = i_t({7'h20, 5'd1}, 5'd8, 3'b101, 5'd9, I);
    prog[9]  = r_t(7'h01, 5'd2, 5'd1, 3'b000, 5'd10);
    prog[10] = r_t(7'h00, 5'd2, 5'd1, 3'b100, 5'd11);
    prog[11] = r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd12);
    prog[12] = r_t(7'h00, 5'd1, 5'd2, 3'b001, 5'd13);
    prog[13] = i_t(12'd5, 5'd1, 3'b000, 5'd0, I);
    prog[14] = b_t(13'd8, 5'd2, 5'd1);
    prog[15] = b_t(13'd8, 5'd0, 5'd0);
    prog[16] = i_t(12'd1, 5'd0, 3'b000, 5'd7, I);
    prog[17] = i_t(12'd7, 5'd0, 3'b000, 5'd14, I);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = (i < 18) ? prog[i] : 32'd0;
    for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = (i == 0) ? 32'd5 : 32'd0;
    for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'd0;

    repeat (2) @(negedge clk_i);
    chk("reset_pc", pc, 32'd0);
    chk("reset_branch", {31'd0, dut.Control.Branch_o}, 32'd0);
    chk("reset_stall", {31'd0, dut.Hazard_Detection_Unit.STALL}, 32'd0);

    rst_i = 1'b0;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("pc_seq", pc, 32'(4 * k));
      @(negedge clk_i);
    end
    #2 rst_i = 1'b1;
    #1 chk("async_reset_pc", pc, 32'd0);
    chk("async_reset_flush", {31'd0, dut.Branch_Unit.FLUSH}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    wait_pc("reach_pc40", 32'd40, 100);
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("hold_pc", pc, 32'd40);
    end
    chk("drain_srai_x9", dut.Registers.register[9], 32'hfffffffc);
    start_i = 1'b1;

    wait_pc("reach_pc80", 32'd80, 200);
    repeat (4) @(negedge clk_i);
    chk("x0", dut.Registers.register[0], 32'd0);
    chk("x1", dut.Registers.register[1], 32'd10);
    chk("x2", dut.Registers.register[2], 32'd3);
    chk("x3_add_fwd", dut.Registers.register[3], 32'd13);
    chk("x4_sub_fwd", dut.Registers.register[4], 32'd3);
    chk("x5_lw", dut.Registers.register[5], 32'd5);
    chk("x6_load_use", dut.Registers.register[6], 32'd10);
    chk("x7_flushed", dut.Registers.register[7], 32'd0);
    chk("x8", dut.Registers.register[8], 32'hfffffff8);
    chk("x10_mul", dut.Registers.register[10], 32'd30);
    chk("x11_xor", dut.Registers.register[11], 32'd9);
    chk("x12_and", dut.Registers.register[12], 32'd2);
    chk("x13_sll", dut.Registers.register[13], 32'd3072);
    chk("x14_target", dut.Registers.register[14], 32'd7);
    chk("mem0", dut.Data_Memory.memory[0], 32'd5);
    chk("mem1_sw", dut.Data_Memory.memory[1], 32'd10);
    chk("stall_count", 32'(n_stall), 32'd1);
    chk("flush_count", 32'(n_flush), 32'd1);
    chk("branch_in_id", 32'(n_branch), 32'd2);
    chk("pc_at_flush", pc_at_flush, 32'd64);
    chk("pc_after_flush", pc_after_flush, 32'd68);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
